ring_router_rr: RTL and testbench

Parametrised 3-port ring router node: next generation of the ring router, with per-input FIFOs of configurable depth and width, destination-based route computation on a ring of configurable size, and per-output round-robin arbitration with valid/ready back-pressure. Port 0 is local (PE side), port 1 is clockwise neighbour, port 2 is counter-clockwise neighbour. One instance per ring node, chained port 1 ↔ neighbour's port 2.

---
 rtl/ring_router_pkg.sv | 39 +++
 rtl/ring_router_fifo.sv | 59 +++++
 rtl/ring_router_rr.sv | 119 +++++++++++
 tb/tb_ring_router_rr.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ring_router_pkg.sv
// Shared definitions for the ring router node: port indices and route computation.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ring_router_pkg;

  localparam int NPORTS = 3;

  localparam logic [1:0] PORT_LOCAL = 2'd0;
  localparam logic [1:0] PORT_CW    = 2'd1;
  localparam logic [1:0] PORT_CCW   = 2'd2;

  // Output port for a flit headed to 'dest' when sitting at 'node_id' on a
  // ring of 'nodes'. Out-of-range destinations are sunk locally. The
  // clockwise distance is formed without a modulo so it maps to an adder,
  // compare and subtract; equal distances either way go clockwise.
  function automatic logic [1:0] route(input int unsigned dest,
                                       input int unsigned node_id,
                                       input int unsigned nodes);
    int unsigned cw;
    if (dest >= nodes || dest == node_id) return PORT_LOCAL;
    cw = dest + nodes - node_id;
    if (cw >= nodes) cw = cw - nodes;
    if (cw <= nodes / 2) return PORT_CW;
    return PORT_CCW;
  endfunction

  // (a + b) mod NPORTS for a, b < NPORTS.
  function automatic logic [1:0] port_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [1:0] port_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/ring_router_fifo.sv
// Synchronous FIFO, registered storage; ports: clk, rst (sync, active-low),
// push/push_data, pop, head, full, empty, count.
// Latency: head valid the cycle after the write. Backpressure: push ignored when full, pop ignored when empty.
module ring_router_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Push qualification uses only 'full': no write-through when a pop frees a
  // slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible through count/empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ring_router_rr.sv
// 3-port ring router node (0 local, 1 clockwise, 2 counter-clockwise); ports: clk, rst (sync, active-low),
// in_data/in_valid/in_ready and out_data/out_valid/out_ready, port p at [p*DATA_W +: DATA_W].
// Latency: 2 edges input to registered output. Backpressure: in_ready = !fifo_full; outputs reload when empty or being taken.
module ring_router_rr
  import ring_router_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int NODES   = 4,
  parameter int DEST_W  = 3,
  parameter int NODE_ID = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS*DATA_W-1:0] in_data,
  input  logic [NPORTS-1:0]        in_valid,
  output logic [NPORTS-1:0]        in_ready,
  output logic [NPORTS*DATA_W-1:0] out_data,
  output logic [NPORTS-1:0]        out_valid,
  input  logic [NPORTS-1:0]        out_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] head [NPORTS];
  logic [1:0]        dir  [NPORTS];
  logic [NPORTS-1:0] full;
  logic [NPORTS-1:0] empty;
  logic [NPORTS-1:0] push;
  logic [NPORTS-1:0] pop;
  logic [CNT_W-1:0]  level_unused [NPORTS];

  // Per-output arbitration results.
  logic [NPORTS-1:0] hit;
  logic [NPORTS-1:0] slot_free;
  logic [1:0]        sel [NPORTS];

  // ---------------- input side: FIFO + route of the head flit ----------------
  for (genvar p = 0; p < NPORTS; p++) begin : g_in
    ring_router_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[p]),
      .push_data(in_data[p*DATA_W +: DATA_W]),
      .pop      (pop[p]),
      .head     (head[p]),
      .full     (full[p]),
      .empty    (empty[p]),
      .count    (level_unused[p])
    );

    assign in_ready[p] = rst && !full[p];
    assign push[p]     = in_valid[p] && in_ready[p];
    assign dir[p]      = route(32'(head[p][DATA_W-1 -: DEST_W]), NODE_ID, NODES);
  end

  // ---------------- output side: round-robin arbiter + output register ----------------
  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    logic [NPORTS-1:0] req;
    logic [1:0]        ptr;
    logic [1:0]        cand;
    logic [1:0]        sel_l;
    logic              hit_l;

    always_comb begin
      req = '0;
      for (int i = 0; i < NPORTS; i++) begin
        req[i] = !empty[i] && (dir[i] == 2'(o));
      end
    end

    // First requester at or after ptr, wrapping around the three inputs.
    always_comb begin
      hit_l = 1'b0;
      sel_l = ptr;
      cand  = ptr;
      for (int k = 0; k < NPORTS; k++) begin
        cand = port_add(ptr, 2'(k));
        if (!hit_l && req[cand]) begin
          hit_l = 1'b1;
          sel_l = cand;
        end
      end
    end

    assign hit[o]       = hit_l;
    assign sel[o]       = sel_l;
    assign slot_free[o] = !out_valid[o] || out_ready[o];

    // ptr only moves on an actual transfer, so a stalled output keeps its
    // fairness position.
    always_ff @(posedge clk) begin
      if (!rst) begin
        out_valid[o]                <= 1'b0;
        out_data[o*DATA_W +: DATA_W] <= '0;
        ptr                         <= '0;
      end else if (hit_l && slot_free[o]) begin
        out_valid[o]                <= 1'b1;
        out_data[o*DATA_W +: DATA_W] <= head[sel_l];
        ptr                         <= port_inc(sel_l);
      end else if (out_ready[o]) begin
        out_valid[o] <= 1'b0;
      end
    end
  end

  // Each head routes to a single output, so at most one output can pop a
  // given FIFO in a cycle.
  always_comb begin
    pop = '0;
    for (int o = 0; o < NPORTS; o++) begin
      if (hit[o] && slot_free[o]) pop[sel[o]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_ring_router_rr.sv
// Directed bench for ring_router_rr at NODES=4, NODE_ID=1, DEPTH=4, DATA_W=8.
// Latency: n/a. Backpressure: bench drives out_ready directly.
module tb_ring_router_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] in_data;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [23:0] out_data;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ring_router_rr #(
    .DATA_W (8),
    .DEPTH  (4),
    .NODES  (4),
    .DEST_W (3),
    .NODE_ID(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b0;
    in_valid = '0;
    repeat (n) cyc();
    rst = 1'b1;
    #1;
  endtask

  // Flit = {dest[2:0], payload[4:0]}
  function automatic logic [7:0] fl(input int d, input int pl);
    return {d[2:0], pl[4:0]};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int rd [4];
    int rp [4];
    int k;
    rd = '{1, 2, 3, 0};
    rp = '{0, 1, 1, 2};

    // ---- reset with inputs offered ----
    rst       = 1'b0;
    in_valid  = 3'b111;
    in_data   = '0;
    out_ready = '0;
    repeat (3) cyc();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst      = 1'b1;
    in_valid = '0;
    #1;
    chk("rel_in_ready", in_ready, 3'b111);

    // ---- routing from local port at node 1 ----
    out_ready = 3'b111;
    for (int i = 0; i < 4; i++) begin
      in_data[7:0] = fl(rd[i], i + 4);
      in_valid     = 3'b001;
      cyc();
      in_valid = '0;
      chk("route_early", out_valid, 0);
      cyc();
      chk("route_vld", out_valid, 32'(1 << rp[i]));
      chk("route_dat", out_data[rp[i]*8 +: 8], fl(rd[i], i + 4));
      cyc();
      chk("route_drain", out_valid, 0);
    end

    // ---- contention on output 0: grant order 0,1,2,... ----
    do_reset(1);
    out_ready = 3'b111;
    for (int c = 0; c < 12; c++) begin
      if (c < 3) begin
        for (int p = 0; p < 3; p++) in_data[p*8 +: 8] = fl(1, p * 8 + c);
        in_valid = 3'b111;
      end else begin
        in_valid = '0;
      end
      cyc();
      if (c >= 1 && c <= 9) begin
        k = c - 1;
        chk("cont_vld", out_valid[0], 1);
        chk("cont_dat", out_data[7:0], fl(1, (k % 3) * 8 + k / 3));
      end
      if (c == 10) chk("cont_idle", out_valid[0], 0);
    end

    // ---- back-pressure and FIFO full on input 1 ----
    do_reset(1);
    out_ready = '0;
    for (int j = 0; j < 5; j++) begin
      in_data[15:8] = fl(1, j);
      in_valid      = 3'b010;
      cyc();
      chk("bp_fill_rdy", in_ready[1], (j < 4) ? 1 : 0);
    end
    in_data[15:8] = fl(1, 5);
    repeat (2) begin
      cyc();
      chk("bp_full", in_ready[1], 0);
    end
    chk("bp_vld", out_valid[0], 1);
    chk("bp_head", out_data[7:0], fl(1, 0));
    in_valid     = '0;
    out_ready[0] = 1'b1;
    for (int j = 1; j < 5; j++) begin
      cyc();
      chk("bp_drain_vld", out_valid[0], 1);
      chk("bp_drain_dat", out_data[7:0], fl(1, j));
      if (j == 1) chk("bp_rdy_back", in_ready[1], 1);
    end
    cyc();
    chk("bp_empty", out_valid[0], 0);

    // ---- three inputs to three distinct outputs ----
    do_reset(1);
    out_ready = 3'b111;
    in_data   = {fl(0, 2), fl(2, 1), fl(1, 0)};
    in_valid  = 3'b111;
    cyc();
    in_valid = '0;
    chk("conc_early", out_valid, 0);
    cyc();
    chk("conc_vld", out_valid, 3'b111);
    chk("conc_dat", out_data, {fl(0, 2), fl(2, 1), fl(1, 0)});

    // ---- reset while FIFOs hold traffic ----
    out_ready = '0;
    in_data   = {8'h00, fl(3, 9), fl(1, 9)};
    in_valid  = 3'b011;
    repeat (2) cyc();
    rst      = 1'b0;
    in_valid = '0;
    cyc();
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_dat", out_data, 0);
    chk("mid_rst_rdy", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rel_rdy", in_ready, 3'b111);
    out_ready = 3'b111;
    repeat (3) begin
      cyc();
      chk("mid_empty", out_valid, 0);
    end
    in_data  = {fl(1, 22), fl(1, 21), fl(1, 20)};
    in_valid = 3'b111;
    cyc();
    in_valid = '0;
    for (int j = 0; j < 3; j++) begin
      cyc();
      chk("mid_order", out_data[7:0], fl(1, 20 + j));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
